lut_layer_sequencer: RTL and testbench
======================================

Name: lut_layer_sequencer

Overview:
- Time-multiplexed evaluator for one layer of LUT neurons (FANIN-bit address, 1-bit output).
- Holds NEURONS programmable truth tables plus a per-neuron fan-in wiring map, and evaluates one neuron per clock.
- Takes an input activation vector over a valid/ready stream, sequences all neurons and returns the packed output vector.
- Used wherever a layer is too large to unroll into fixed per-neuron ROM modules; sits between two layer streams.

Parameters:
- IN_BITS, 64, width of the input activation vector.
- NEURONS, 16, number of neurons evaluated per input vector.
- FANIN, 8, address bits per neuron truth table (2^FANIN entries).
- Derived, not overridable: IDX_W = clog2(IN_BITS), NW = clog2(NEURONS), SW = clog2(FANIN).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- tt_we  in  1  truth-table write strobe.
- tt_neuron  in  NW  neuron index for the truth-table write.
- tt_addr  in  FANIN  truth-table entry for the write.
- tt_data  in  1  output bit to store.
- map_we  in  1  wiring-map write strobe.
- map_neuron  in  NW  neuron index for the map write.
- map_slot  in  SW  fan-in slot (address bit position) for the map write.
- map_idx  in  IDX_W  input-vector bit that drives this slot.
- cfg_err  out  1  one-cycle pulse when a config write is dropped.
- s_valid  in  1  input vector valid.
- s_ready  out  1  sequencer can accept an input vector.
- s_data  in  IN_BITS  input activation vector.
- m_valid  out  1  output vector valid.
- m_ready  in  1  downstream accepts the output vector.
- m_data  out  NEURONS  packed outputs; bit k belongs to neuron k.
- busy  out  1  high in EVAL or DONE.

Behaviour:
- Reset values: state=IDLE, s_ready=1, m_valid=0, m_data=0, busy=0, cfg_err=0, neuron counter=0.
- Truth-table and map storage is not reset; the bench must program every used entry before streaming.
- All outputs are registered.
- States:
  - IDLE: s_ready=1. When s_valid && s_ready, latch s_data into in_reg, clear m_data, cnt=0, go to EVAL.
  - EVAL: each cycle, for neuron k=cnt, form address a with a[j] = in_reg[map[k][j]] for j in 0..FANIN-1; slot 0 is address LSB. Write m_data[k] = tt[k][a]. cnt increments; after k=NEURONS-1, go to DONE and set m_valid=1 on the same edge.
  - DONE: hold m_valid and m_data stable until m_ready. On m_valid && m_ready, clear m_valid, set s_ready=1 and go to IDLE.
- s_ready drops on the edge where the input handshake occurs.
- Latency:
  - m_valid rises NEURONS edges after the input handshake edge.
  - Minimum interval between accepted inputs is NEURONS+2 cycles.
  - No overlap between vectors; a new input is never accepted while in EVAL or DONE.
- Out-of-range map: if map[k][j] >= IN_BITS, that address bit reads 0.
- Config writes:
  - Accepted only in IDLE, and not on the cycle of an input handshake.
  - Otherwise the write is dropped and cfg_err pulses for one cycle.
  - tt_we and map_we in the same cycle are both applied.
  - Out-of-range tt_neuron or map_neuron (>= NEURONS) is dropped with cfg_err.
  - A write accepted in cycle t affects any vector accepted at t+1 or later.
- m_ready while m_valid=0 is ignored. s_valid may be deasserted at any time in IDLE with no effect.
- Asynchronous reset mid-EVAL or mid-DONE:
  - Immediately returns to reset values; the in-flight vector is discarded.
  - Tables keep their contents (no reset on storage).
- The counter never wraps past NEURONS-1; NEURONS need not be a power of two.

Test Plan:
1. Identity check:
   - Setup: map[k][j] = k*4+j (mod 64); tt[k][a] = parity(a); s_data=64'h0123_4567_89AB_CDEF.
   - Required: m_valid exactly 16 edges after the handshake; m_data equals the per-neuron parity reference.
2. Reference-style neuron:
   - Setup: neuron 0 programmed with tt[0][a]=0 for a[5]=1 && a[4]=0, else 1; map slots 0..7 -> input bits 0..7.
   - Required: s_data[7:0]=8'h20 gives m_data[0]=0; 8'h30 gives 1; 8'h00 gives 1.
3. Backpressure:
   - Setup: hold m_ready=0 for 10 cycles after m_valid.
   - Required: m_data stable, s_ready=0, s_valid ignored; m_ready=1 gives s_ready=1 next cycle.
4. Config guard:
   - tt_we during EVAL: cfg_err pulses, result unchanged from expected.
   - Same write in IDLE: no cfg_err, and the next vector reflects the new entry.
5. Out-of-range map:
   - Setup: map[3][2]=70 (IDX_W=6 wraps to 6); repeat with IN_BITS=48 and map_idx=50.
   - Required: that bit reads 0, and neuron 3 output matches the model.
6. Reset mid-EVAL:
   - Stimulus: rst_n low at cycle 5 of EVAL, then release.
   - Required: m_valid=0, s_ready=1, m_data=0; the next vector evaluates correctly with tables intact.

Source files
------------

// File: rtl/lut_layer_sequencer.sv
// lut_layer_sequencer
// Evaluates one layer of programmable LUT neurons, one neuron per clock.
// An input vector is taken over a valid/ready stream, every neuron is
// looked up through its own fan-in wiring map, and the packed result is
// presented on an output valid/ready stream. Tables are not reset.
module lut_layer_sequencer #(
   parameter  int IN_BITS = 64,
   parameter  int NEURONS = 16,
   parameter  int FANIN   = 8,
   localparam int IDX_W   = $clog2(IN_BITS),
   localparam int NW      = $clog2(NEURONS),
   localparam int SW      = $clog2(FANIN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tt_we,
   input  logic [NW-1:0]      tt_neuron,
   input  logic [FANIN-1:0]   tt_addr,
   input  logic               tt_data,
   input  logic               map_we,
   input  logic [NW-1:0]      map_neuron,
   input  logic [SW-1:0]      map_slot,
   input  logic [IDX_W-1:0]   map_idx,
   output logic               cfg_err,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [IN_BITS-1:0] s_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [NEURONS-1:0] m_data,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   localparam logic [NW-1:0] LAST = NW'(NEURONS - 1);

   state_t                 state;
   logic [NW-1:0]          cnt;
   logic [IN_BITS-1:0]     in_reg;
   logic [FANIN-1:0]       addr;
   logic [2**FANIN-1:0]    tt_mem  [NEURONS];
   logic [IDX_W-1:0]       map_mem [NEURONS][FANIN];

   logic hs;
   logic cfg_open;
   logic tt_ok;
   logic map_ok;

   // Config is only taken while idle and never on the edge that accepts a vector,
   // so a vector always sees one consistent set of tables.
   assign hs       = s_valid && s_ready;
   assign cfg_open = (state == IDLE) && !hs;
   assign tt_ok    = tt_we  && cfg_open && (int'(tt_neuron)  < NEURONS);
   assign map_ok   = map_we && cfg_open && (int'(map_neuron) < NEURONS);

   // Truth-table and wiring-map storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (tt_ok)  tt_mem[tt_neuron][tt_addr]    <= tt_data;
      if (map_ok) map_mem[map_neuron][map_slot] <= map_idx;
   end

   // Input vector capture on the accept handshake.
   always_ff @(posedge clk) begin
      if (hs) in_reg <= s_data;
   end

   // Gather the current neuron's address bits; unmapped input positions read 0.
   always_comb begin
      addr = '0;
      for (int j = 0; j < FANIN; j++) begin
         if (int'(map_mem[cnt][j]) < IN_BITS) addr[j] = in_reg[map_mem[cnt][j]];
      end
   end

   // Sequencer FSM with all stream and status outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         s_ready <= 1'b1;
         m_valid <= 1'b0;
         m_data  <= '0;
         busy    <= 1'b0;
         cfg_err <= 1'b0;
         cnt     <= '0;
      end else begin
         cfg_err <= (tt_we && !tt_ok) || (map_we && !map_ok);
         case (state)
            IDLE: begin
               if (hs) begin
                  s_ready <= 1'b0;
                  m_data  <= '0;
                  cnt     <= '0;
                  busy    <= 1'b1;
                  state   <= EVAL;
               end
            end
            EVAL: begin
               m_data[cnt] <= tt_mem[cnt][addr];
               if (cnt == LAST) begin
                  m_valid <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + NW'(1);
               end
            end
            DONE: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  s_ready <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lut_layer_sequencer.sv
// tb_lut_layer_sequencer
// Directed bench for lut_layer_sequencer: a 64-bit and a 48-bit instance
// share all stimulus so out-of-range wiring can be checked side by side.
module tb_lut_layer_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tt_we, tt_data, map_we, s_valid, m_ready;
   logic [3:0]  tt_neuron, map_neuron;
   logic [7:0]  tt_addr;
   logic [2:0]  map_slot;
   logic [5:0]  map_idx;
   logic [63:0] s_data;
   logic        cfg_err, s_ready, m_valid, busy;
   logic [15:0] m_data;
   logic        cfg_err48, s_ready48, m_valid48, busy48;
   logic [15:0] m_data48;

   logic [255:0] tt_m  [16];
   logic [5:0]   map_m [16][8];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   lut_layer_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .tt_we(tt_we), .tt_neuron(tt_neuron), .tt_addr(tt_addr), .tt_data(tt_data),
      .map_we(map_we), .map_neuron(map_neuron), .map_slot(map_slot), .map_idx(map_idx),
      .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
   );

   lut_layer_sequencer #(.IN_BITS(48)) dut48 (
      .clk(clk), .rst_n(rst_n),
      .tt_we(tt_we), .tt_neuron(tt_neuron), .tt_addr(tt_addr), .tt_data(tt_data),
      .map_we(map_we), .map_neuron(map_neuron), .map_slot(map_slot), .map_idx(map_idx),
      .cfg_err(cfg_err48), .s_valid(s_valid), .s_ready(s_ready48), .s_data(s_data[47:0]),
      .m_valid(m_valid48), .m_ready(m_ready), .m_data(m_data48), .busy(busy48)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] addr_of(input logic [63:0] d, input int k, input int inb);
      logic [7:0] a;
      for (int j = 0; j < 8; j++)
         a[j] = (int'(map_m[k][j]) < inb) ? d[map_m[k][j]] : 1'b0;
      return a;
   endfunction

   function automatic logic [15:0] model(input logic [63:0] d, input int inb);
      logic [15:0] r;
      for (int k = 0; k < 16; k++) r[k] = tt_m[k][addr_of(d, k, inb)];
      return r;
   endfunction

   task automatic wr_tt(input int n, input int a, input logic d);
      tt_we = 1'b1; tt_neuron = 4'(n); tt_addr = 8'(a); tt_data = d;
      @(posedge clk); #1;
      tt_we = 1'b0;
   endtask

   task automatic wr_map(input int n, input int s, input logic [5:0] idx);
      map_we = 1'b1; map_neuron = 4'(n); map_slot = 3'(s); map_idx = idx;
      @(posedge clk); #1;
      map_we = 1'b0;
   endtask

   task automatic wait_valid(input string tag, output int lat);
      lat = 0;
      while (!m_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_mvalid"}, 64'(m_valid), 64'd1);
   endtask

   task automatic release_out(input string tag);
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
      chk({tag, "_sready"}, 64'(s_ready), 64'd1);
      chk({tag, "_mvalid0"}, 64'(m_valid), 64'd0);
   endtask

   task automatic run_vec(input string tag, input logic [63:0] d);
      int lat;
      logic [15:0] e64, e48;
      e64 = model(d, 64);
      e48 = model(d, 48);
      s_data = d; s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      wait_valid(tag, lat);
      chk({tag, "_lat"}, 64'(lat), 64'd16);
      chk({tag, "_mv48"}, 64'(m_valid48), 64'd1);
      chk({tag, "_d64"}, 64'(m_data), 64'(e64));
      chk({tag, "_d48"}, 64'(m_data48), 64'(e48));
      release_out(tag);
   endtask

   initial begin
      int lat;
      logic [15:0] snap, e64;
      logic [63:0] d;
      logic [7:0] a8;
      logic nb;

      rst_n = 1'b0; tt_we = 1'b0; map_we = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
      tt_neuron = '0; tt_addr = '0; tt_data = 1'b0;
      map_neuron = '0; map_slot = '0; map_idx = '0; s_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sready", 64'(s_ready), 64'd1);
      chk("rst_mvalid", 64'(m_valid), 64'd0);
      chk("rst_mdata", 64'(m_data), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_cfgerr", 64'(cfg_err), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // identity wiring with parity tables
      for (int k = 0; k < 16; k++) begin
         for (int j = 0; j < 8; j++) begin
            map_m[k][j] = 6'((k * 4 + j) % 64);
            wr_map(k, j, map_m[k][j]);
         end
         for (int a = 0; a < 256; a++) begin
            a8 = 8'(a);
            tt_m[k][a] = ^a8;
            wr_tt(k, a, ^a8);
         end
      end
      chk("cfg_idle_ok", 64'(cfg_err), 64'd0);
      run_vec("ident", 64'h0123_4567_89AB_CDEF);
      run_vec("ident2", 64'hFFFF_0000_A5A5_5A5A);

      // neuron 0 outputs 0 only when a[5]=1 and a[4]=0
      for (int a = 0; a < 256; a++) begin
         a8 = 8'(a);
         tt_m[0][a] = !(a8[5] && !a8[4]);
         wr_tt(0, a, tt_m[0][a]);
      end
      run_vec("ref20", 64'h20);
      chk("ref20_bit0", 64'(m_data[0]), 64'd0);
      run_vec("ref30", 64'h30);
      chk("ref30_bit0", 64'(m_data[0]), 64'd1);
      run_vec("ref00", 64'h00);
      chk("ref00_bit0", 64'(m_data[0]), 64'd1);

      // backpressure: output held, new inputs refused
      d = 64'h1357_9BDF_0246_8ACE;
      e64 = model(d, 64);
      s_data = d; s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      wait_valid("bp", lat);
      chk("bp_data", 64'(m_data), 64'(e64));
      snap = m_data;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1; s_data = 64'(i) * 64'h1111_1111_1111_1111;
         @(posedge clk); #1;
         chk("bp_stable", 64'(m_data), 64'(snap));
         chk("bp_sready", 64'(s_ready), 64'd0);
         chk("bp_busy", 64'(busy), 64'd1);
      end
      s_valid = 1'b0;
      release_out("bp");

      // config guard: writes on the accept edge and during EVAL are dropped
      d = 64'hDEAD_BEEF_0BAD_F00D;
      a8 = addr_of(d, 5, 64);
      nb = ~tt_m[5][a8];
      e64 = model(d, 64);
      s_data = d; s_valid = 1'b1;
      tt_we = 1'b1; tt_neuron = 4'd5; tt_addr = a8; tt_data = nb;
      @(posedge clk); #1;
      s_valid = 1'b0; tt_we = 1'b0;
      chk("cg_hs_err", 64'(cfg_err), 64'd1);
      @(posedge clk); #1;
      chk("cg_err_clr", 64'(cfg_err), 64'd0);
      wr_tt(5, a8, nb);
      chk("cg_eval_err", 64'(cfg_err), 64'd1);
      wait_valid("cg", lat);
      chk("cg_unchanged", 64'(m_data), 64'(e64));
      release_out("cg");
      wr_tt(5, a8, nb);
      chk("cg_idle_err", 64'(cfg_err), 64'd0);
      tt_m[5][a8] = nb;
      run_vec("cg_new", d);
      chk("cg_new_bit5", 64'(m_data[5]), 64'(nb));

      // out-of-range wiring: 70 truncates to 6; 50 is unmapped on the 48-bit instance
      wr_map(3, 2, 6'(70));
      map_m[3][2] = 6'(70);
      wr_map(3, 3, 6'd50);
      map_m[3][3] = 6'd50;
      run_vec("oor", 64'h0004_0000_0000_0040);
      chk("oor_n3_64", 64'(m_data[3]), 64'd0);
      chk("oor_n3_48", 64'(m_data48[3]), 64'd1);

      // asynchronous reset mid-EVAL, tables retained
      s_data = 64'hCAFE_F00D_1234_5678; s_valid = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_mvalid", 64'(m_valid), 64'd0);
      chk("mrst_sready", 64'(s_ready), 64'd1);
      chk("mrst_mdata", 64'(m_data), 64'd0);
      chk("mrst_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec("post_rst", 64'hCAFE_F00D_1234_5678);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
